alarm_display_controller: RTL and testbench

Sequences the alarm-clock display and setting modes. It decodes debounced user buttons into a mode state machine that drives the time/alarm display select. It also issues single-cycle increment strobes to the time and alarm counters, and generates digit-blink and clock-hold controls. The block sits between the button debouncers and the display multiplexer / time-keeping counters.

---
 rtl/alarm_display_controller.sv | 274 +++++++++++++++++++++++++++
 tb/tb_alarm_display_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_display_controller.sv
// ---------------------------------------------------------------------------
// alarm_display_controller
//
// Purpose:
//   Mode sequencer for an alarm clock. Debounced button levels are edge
//   detected and drive a six-state mode machine (TIME, ALARM and four
//   setting states). The block selects the time or alarm display, issues
//   one-cycle increment strobes to the time and alarm hour/minute counters,
//   blinks the digits being set, freezes the seconds counter while the time
//   is being set, and returns to TIME after a period of inactivity.
//
// Optional feature:
//   AUTO_REPEAT_EN - when defined, holding Inc in a setting state produces
//   auto-repeat strobes (first after REPEAT_DELAY_CYCLES, then every
//   REPEAT_PERIOD_CYCLES). When undefined the repeat logic is not built.
//
// Ports:
//   i_Clk            system clock, rising edge
//   i_Rst_L          asynchronous active-low reset
//   i_Mode_Btn       debounced mode button level
//   i_Set_Btn        debounced set button level
//   i_Inc_Btn        debounced increment button level
//   i_Sec_Tick       one-cycle pulse once per second
//   o_Display_Sel    0 = time display, 1 = alarm display
//   o_Time_Hr_Inc    one-cycle strobe, time hours +1
//   o_Time_Min_Inc   one-cycle strobe, time minutes +1
//   o_Alarm_Hr_Inc   one-cycle strobe, alarm hours +1
//   o_Alarm_Min_Inc  one-cycle strobe, alarm minutes +1
//   o_Blank_Hr       blank hour digits (blink-off phase)
//   o_Blank_Min      blank minute digits (blink-off phase)
//   o_Clock_Hold     freeze seconds counter while setting time
// ---------------------------------------------------------------------------
module alarm_display_controller #(
  parameter int TIMEOUT_SEC          = 10,
  parameter int BLINK_HALF_CYCLES    = 12_500_000,
  parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Mode_Btn,
  input  logic i_Set_Btn,
  input  logic i_Inc_Btn,
  input  logic i_Sec_Tick,
  output logic o_Display_Sel,
  output logic o_Time_Hr_Inc,
  output logic o_Time_Min_Inc,
  output logic o_Alarm_Hr_Inc,
  output logic o_Alarm_Min_Inc,
  output logic o_Blank_Hr,
  output logic o_Blank_Min,
  output logic o_Clock_Hold
);

  // Elaboration-time parameter range checks.
  if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 255) begin : g_bad_timeout
    $error("TIMEOUT_SEC must be in 1..255");
  end
  if (BLINK_HALF_CYCLES < 2) begin : g_bad_blink
    $error("BLINK_HALF_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY_CYCLES < 2 || REPEAT_PERIOD_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_DELAY_CYCLES and REPEAT_PERIOD_CYCLES must be >= 2");
  end

  localparam int BLINK_W = $clog2(BLINK_HALF_CYCLES);

  typedef enum logic [2:0] {
    ST_TIME,
    ST_ALARM,
    ST_SET_T_HR,
    ST_SET_T_MIN,
    ST_SET_A_HR,
    ST_SET_A_MIN
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           btn_prev_q, btn_prev_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_off_q, blink_off_d;
  logic                 display_sel_q, display_sel_d;
  logic                 time_hr_inc_q, time_hr_inc_d;
  logic                 time_min_inc_q, time_min_inc_d;
  logic                 alarm_hr_inc_q, alarm_hr_inc_d;
  logic                 alarm_min_inc_q, alarm_min_inc_d;
  logic                 blank_hr_q, blank_hr_d;
  logic                 blank_min_q, blank_min_d;
  logic                 clock_hold_q, clock_hold_d;

  logic                 mode_press, set_press, inc_press;
  logic                 in_set, next_in_set;
  logic                 rpt_fire;
  logic                 activity;
  logic                 state_changed;
  logic                 strobe;
  state_t               btn_next;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX);

  // rpt_cnt counts down the cycles left until the next repeat strobe;
  // rpt_act marks that the current Inc hold started with a press in a
  // setting state, so a level merely held into a setting state never repeats.
  logic             rpt_act_q, rpt_act_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  always_comb begin
    btn_prev_d = {i_Mode_Btn, i_Set_Btn, i_Inc_Btn};
    mode_press = i_Mode_Btn & ~btn_prev_q[2];
    set_press  = i_Set_Btn  & ~btn_prev_q[1];
    inc_press  = i_Inc_Btn  & ~btn_prev_q[0];

    in_set = (state_q == ST_SET_T_HR) || (state_q == ST_SET_T_MIN) ||
             (state_q == ST_SET_A_HR) || (state_q == ST_SET_A_MIN);

    // Button-driven transition; Set is tested first so it wins over Mode.
    btn_next = state_q;
    case (state_q)
      ST_TIME: begin
        if (set_press)       btn_next = ST_SET_T_HR;
        else if (mode_press) btn_next = ST_ALARM;
      end
      ST_ALARM: begin
        if (set_press)       btn_next = ST_SET_A_HR;
        else if (mode_press) btn_next = ST_TIME;
      end
      ST_SET_T_HR: begin
        if (set_press)       btn_next = ST_SET_T_MIN;
        else if (mode_press) btn_next = ST_TIME;
      end
      ST_SET_T_MIN: begin
        if (set_press)       btn_next = ST_TIME;
        else if (mode_press) btn_next = ST_TIME;
      end
      ST_SET_A_HR: begin
        if (set_press)       btn_next = ST_SET_A_MIN;
        else if (mode_press) btn_next = ST_TIME;
      end
      ST_SET_A_MIN: begin
        if (set_press)       btn_next = ST_ALARM;
        else if (mode_press) btn_next = ST_TIME;
      end
      default:               btn_next = ST_TIME;
    endcase

    // Repeat strobes only fire while the state is otherwise unchanged, which
    // keeps this term free of the timeout decision below.
    rpt_fire = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_fire = rpt_act_q & i_Inc_Btn & in_set & (btn_next == state_q) &
               (rpt_cnt_q == '0);
`endif

    activity = mode_press | set_press | inc_press | rpt_fire;

    // Any activity in the terminal cycle suppresses the timeout.
    state_d = btn_next;
    if ((btn_next == state_q) && !activity && (state_q != ST_TIME) &&
        (tmo_q == 8'(TIMEOUT_SEC))) begin
      state_d = ST_TIME;
    end
    state_changed = (state_d != state_q);

    if ((state_q == ST_TIME) || activity || state_changed) begin
      tmo_d = 8'd0;
    end else if (i_Sec_Tick) begin
      tmo_d = tmo_q + 8'd1;
    end else begin
      tmo_d = tmo_q;
    end

`ifdef AUTO_REPEAT_EN
    rpt_act_d = rpt_act_q;
    rpt_cnt_d = rpt_cnt_q;
    if (state_changed || !i_Inc_Btn) begin
      rpt_act_d = 1'b0;
      rpt_cnt_d = '0;
    end else if (inc_press && in_set) begin
      rpt_act_d = 1'b1;
      rpt_cnt_d = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    end else if (rpt_fire) begin
      rpt_cnt_d = RPT_W'(REPEAT_PERIOD_CYCLES - 1);
    end else if (rpt_act_q && (rpt_cnt_q != '0)) begin
      rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
    end
`endif

    // Strobes always target the state the press was seen in.
    strobe          = (inc_press | rpt_fire) & in_set;
    time_hr_inc_d   = strobe & (state_q == ST_SET_T_HR);
    time_min_inc_d  = strobe & (state_q == ST_SET_T_MIN);
    alarm_hr_inc_d  = strobe & (state_q == ST_SET_A_HR);
    alarm_min_inc_d = strobe & (state_q == ST_SET_A_MIN);

    next_in_set = (state_d == ST_SET_T_HR) || (state_d == ST_SET_T_MIN) ||
                  (state_d == ST_SET_A_HR) || (state_d == ST_SET_A_MIN);

    // Blink restarts visible on entering a setting state and on every strobe
    // so the digit being changed is always shown right after a change.
    if (!next_in_set || state_changed || strobe) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      blink_off_d = blink_off_q;
    end

    display_sel_d = (state_d == ST_ALARM) || (state_d == ST_SET_A_HR) ||
                    (state_d == ST_SET_A_MIN);
    clock_hold_d  = (state_d == ST_SET_T_HR) || (state_d == ST_SET_T_MIN);
    blank_hr_d    = ((state_d == ST_SET_T_HR) || (state_d == ST_SET_A_HR)) &
                    blink_off_d;
    blank_min_d   = ((state_d == ST_SET_T_MIN) || (state_d == ST_SET_A_MIN)) &
                    blink_off_d;
  end

  // Button history resets high so a button held through reset is not a press.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q         <= ST_TIME;
      btn_prev_q      <= 3'b111;
      tmo_q           <= 8'd0;
      blink_cnt_q     <= '0;
      blink_off_q     <= 1'b0;
      display_sel_q   <= 1'b0;
      time_hr_inc_q   <= 1'b0;
      time_min_inc_q  <= 1'b0;
      alarm_hr_inc_q  <= 1'b0;
      alarm_min_inc_q <= 1'b0;
      blank_hr_q      <= 1'b0;
      blank_min_q     <= 1'b0;
      clock_hold_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_act_q       <= 1'b0;
      rpt_cnt_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      btn_prev_q      <= btn_prev_d;
      tmo_q           <= tmo_d;
      blink_cnt_q     <= blink_cnt_d;
      blink_off_q     <= blink_off_d;
      display_sel_q   <= display_sel_d;
      time_hr_inc_q   <= time_hr_inc_d;
      time_min_inc_q  <= time_min_inc_d;
      alarm_hr_inc_q  <= alarm_hr_inc_d;
      alarm_min_inc_q <= alarm_min_inc_d;
      blank_hr_q      <= blank_hr_d;
      blank_min_q     <= blank_min_d;
      clock_hold_q    <= clock_hold_d;
`ifdef AUTO_REPEAT_EN
      rpt_act_q       <= rpt_act_d;
      rpt_cnt_q       <= rpt_cnt_d;
`endif
    end
  end

  assign o_Display_Sel   = display_sel_q;
  assign o_Time_Hr_Inc   = time_hr_inc_q;
  assign o_Time_Min_Inc  = time_min_inc_q;
  assign o_Alarm_Hr_Inc  = alarm_hr_inc_q;
  assign o_Alarm_Min_Inc = alarm_min_inc_q;
  assign o_Blank_Hr      = blank_hr_q;
  assign o_Blank_Min     = blank_min_q;
  assign o_Clock_Hold    = clock_hold_q;

endmodule

// File: tb/tb_alarm_display_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_display_controller
//
// Self-checking bench for alarm_display_controller with small parameters
// (TIMEOUT_SEC=3, BLINK_HALF_CYCLES=4, REPEAT_DELAY_CYCLES=10,
// REPEAT_PERIOD_CYCLES=4). Outputs are packed as
// {disp, t_hr, t_min, a_hr, a_min, blank_hr, blank_min, hold}.
// ---------------------------------------------------------------------------
module tb_alarm_display_controller;

  localparam int TMO  = 3;
  localparam int HALF = 4;
  localparam int RPTD = 10;
  localparam int RPTP = 4;

  logic i_Clk = 1'b0;
  logic i_Rst_L = 1'b0;
  logic i_Mode_Btn = 1'b0;
  logic i_Set_Btn = 1'b0;
  logic i_Inc_Btn = 1'b0;
  logic i_Sec_Tick = 1'b0;
  logic o_Display_Sel, o_Time_Hr_Inc, o_Time_Min_Inc, o_Alarm_Hr_Inc;
  logic o_Alarm_Min_Inc, o_Blank_Hr, o_Blank_Min, o_Clock_Hold;
  logic [7:0] dut_out;

  int n_cmp = 0;
  int n_fail = 0;

  alarm_display_controller #(
    .TIMEOUT_SEC(TMO),
    .BLINK_HALF_CYCLES(HALF),
    .REPEAT_DELAY_CYCLES(RPTD),
    .REPEAT_PERIOD_CYCLES(RPTP)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Mode_Btn(i_Mode_Btn),
    .i_Set_Btn(i_Set_Btn),
    .i_Inc_Btn(i_Inc_Btn),
    .i_Sec_Tick(i_Sec_Tick),
    .o_Display_Sel(o_Display_Sel),
    .o_Time_Hr_Inc(o_Time_Hr_Inc),
    .o_Time_Min_Inc(o_Time_Min_Inc),
    .o_Alarm_Hr_Inc(o_Alarm_Hr_Inc),
    .o_Alarm_Min_Inc(o_Alarm_Min_Inc),
    .o_Blank_Hr(o_Blank_Hr),
    .o_Blank_Min(o_Blank_Min),
    .o_Clock_Hold(o_Clock_Hold)
  );

  assign dut_out = {o_Display_Sel, o_Time_Hr_Inc, o_Time_Min_Inc,
                    o_Alarm_Hr_Inc, o_Alarm_Min_Inc, o_Blank_Hr,
                    o_Blank_Min, o_Clock_Hold};

  always #5 i_Clk = ~i_Clk;

  // Reference model: the mode is a (view, field) pair -- view 0 = time,
  // 1 = alarm; field 0 = not setting, 1 = hours, 2 = minutes. Blink phase
  // comes from the age since the last restart, repeat strobes from the
  // length of the current Inc hold.
  int m_view, m_field, m_idle, m_age, m_hold;
  bit pm, ps, pi;
  logic [7:0] m_out;

  task automatic model_reset();
    m_view = 0; m_field = 0; m_idle = 0; m_age = 0; m_hold = 0;
    pm = 1'b1; ps = 1'b1; pi = 1'b1;
    m_out = 8'h00;
  endtask

  task automatic model_step(input bit m, input bit s, input bit i, input bit t);
    bit pmode, pset, pinc, chg_btn, changed, rpt, act, strobe, off;
    int pv, pf;
    pmode = m && !pm;
    pset  = s && !ps;
    pinc  = i && !pi;
    pv = m_view;
    pf = m_field;
    rpt = 1'b0;
`ifdef AUTO_REPEAT_EN
    if (pinc && pf != 0) m_hold = 1;
    else if (i && m_hold > 0) m_hold++;
    else m_hold = 0;
    rpt = (m_hold == RPTD + 1) ||
          (m_hold > RPTD + 1 && ((m_hold - RPTD - 1) % RPTP) == 0);
`endif
    if (pset) begin
      if (pf == 0) m_field = 1;
      else if (pf == 1) m_field = 2;
      else m_field = 0;
    end else if (pmode) begin
      if (pf != 0) begin m_view = 0; m_field = 0; end
      else m_view = 1 - m_view;
    end
    chg_btn = (m_view != pv) || (m_field != pf);
    if (chg_btn) rpt = 1'b0;
    act = pmode || pset || pinc || rpt;
    if (!chg_btn && !act && (pv != 0 || pf != 0) && m_idle == TMO) begin
      m_view = 0; m_field = 0;
    end
    changed = (m_view != pv) || (m_field != pf);
    if (changed) m_hold = 0;
    strobe = (pinc || rpt) && (pf != 0);
    if ((m_view == 0 && m_field == 0) || changed || act) m_idle = 0;
    else if (t) m_idle++;
    if (m_field == 0 || changed || strobe) m_age = 0;
    else m_age++;
    off = ((m_age / HALF) % 2) == 1;
    m_out = {m_view == 1,
             strobe && pv == 0 && pf == 1, strobe && pv == 0 && pf == 2,
             strobe && pv == 1 && pf == 1, strobe && pv == 1 && pf == 2,
             m_field == 1 && off, m_field == 2 && off,
             m_field != 0 && m_view == 0};
    pm = m; ps = s; pi = i;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    n_cmp++;
    if (dut_out !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @%0t: got %b expected %b", name, $time, dut_out, exp);
    end
  endtask

  // Drive {mode,set,inc,tick} at the falling edge, step the model at the
  // rising edge and leave the caller 1 time unit after the edge.
  task automatic applyStimulus(input logic [3:0] in);
    @(negedge i_Clk);
    i_Mode_Btn = in[3];
    i_Set_Btn  = in[2];
    i_Inc_Btn  = in[1];
    i_Sec_Tick = in[0];
    @(posedge i_Clk);
    model_step(in[3], in[2], in[1], in[0]);
    #1;
  endtask

  typedef struct {
    logic [3:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[36];

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] lv;
    logic [21:0] got_mask, exp_mask;
    int extra;

    tbl[0]  = '{4'b0000, 8'b0000_0000};
    tbl[1]  = '{4'b1000, 8'b1000_0000};
    tbl[2]  = '{4'b0000, 8'b1000_0000};
    tbl[3]  = '{4'b1000, 8'b0000_0000};
    tbl[4]  = '{4'b0000, 8'b0000_0000};
    tbl[5]  = '{4'b1100, 8'b0000_0001};
    tbl[6]  = '{4'b0010, 8'b0100_0001};
    tbl[7]  = '{4'b0000, 8'b0000_0001};
    tbl[8]  = '{4'b0010, 8'b0100_0001};
    tbl[9]  = '{4'b0000, 8'b0000_0001};
    tbl[10] = '{4'b0000, 8'b0000_0001};
    tbl[11] = '{4'b0000, 8'b0000_0001};
    tbl[12] = '{4'b0000, 8'b0000_0101};
    tbl[13] = '{4'b0000, 8'b0000_0101};
    tbl[14] = '{4'b0100, 8'b0000_0001};
    tbl[15] = '{4'b0010, 8'b0010_0001};
    tbl[16] = '{4'b0000, 8'b0000_0001};
    tbl[17] = '{4'b1000, 8'b0000_0000};
    tbl[18] = '{4'b0001, 8'b0000_0000};
    tbl[19] = '{4'b1000, 8'b1000_0000};
    tbl[20] = '{4'b0001, 8'b1000_0000};
    tbl[21] = '{4'b0001, 8'b1000_0000};
    tbl[22] = '{4'b0000, 8'b1000_0000};
    tbl[23] = '{4'b0001, 8'b1000_0000};
    tbl[24] = '{4'b0000, 8'b0000_0000};
    tbl[25] = '{4'b1000, 8'b1000_0000};
    tbl[26] = '{4'b0001, 8'b1000_0000};
    tbl[27] = '{4'b0001, 8'b1000_0000};
    tbl[28] = '{4'b0011, 8'b1000_0000};
    tbl[29] = '{4'b0000, 8'b1000_0000};
    tbl[30] = '{4'b0100, 8'b1000_0000};
    tbl[31] = '{4'b0000, 8'b1000_0000};
    tbl[32] = '{4'b0110, 8'b1001_0000};
    tbl[33] = '{4'b0000, 8'b1000_0000};
    tbl[34] = '{4'b0100, 8'b1000_0000};
    tbl[35] = '{4'b0000, 8'b1000_0000};

    // Reset with all buttons held high, then release with them still high.
    i_Rst_L = 1'b0;
    i_Mode_Btn = 1'b1; i_Set_Btn = 1'b1; i_Inc_Btn = 1'b1;
    model_reset();
    repeat (3) @(posedge i_Clk);
    #1;
    checkOutput("reset_state", 8'h00);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1110);
      checkOutput("held_through_reset", 8'h00);
      checkOutput("model_held", m_out);
    end
    applyStimulus(4'b0000);
    checkOutput("release_idle", 8'h00);

    // Directed table.
    for (int k = 0; k < 36; k++) begin
      applyStimulus(tbl[k].in);
      checkOutput($sformatf("table[%0d]", k), tbl[k].exp);
      checkOutput($sformatf("model_table[%0d]", k), m_out);
    end

    // Randomized levels with occasional toggles, checked against the model.
    lv = 4'b0000;
    for (int k = 0; k < 4000; k++) begin
      for (int b = 1; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) lv[b] = ~lv[b];
      end
      lv[0] = ($urandom_range(0, 2) == 0);
      applyStimulus(lv);
      checkOutput("random", m_out);
    end

    // Fresh reset, then TIME -> ALARM -> SET_A_HR -> SET_A_MIN.
    @(negedge i_Clk);
    i_Rst_L = 1'b0;
    i_Mode_Btn = 1'b0; i_Set_Btn = 1'b0; i_Inc_Btn = 1'b0; i_Sec_Tick = 1'b0;
    model_reset();
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    applyStimulus(4'b0000);
    applyStimulus(4'b1000);
    applyStimulus(4'b0000);
    applyStimulus(4'b0100);
    applyStimulus(4'b0000);
    applyStimulus(4'b0100);
    checkOutput("enter_set_a_min", 8'b1000_0000);
    applyStimulus(4'b0000);

    // Hold Inc for 22 cycles and record the strobe positions.
    got_mask = '0;
    for (int k = 0; k < 22; k++) begin
      applyStimulus(4'b0010);
      checkOutput("model_hold", m_out);
      got_mask[k] = o_Alarm_Min_Inc;
    end
`ifdef AUTO_REPEAT_EN
    exp_mask = 22'b0;
    exp_mask[0] = 1'b1; exp_mask[10] = 1'b1; exp_mask[14] = 1'b1; exp_mask[18] = 1'b1;
`else
    exp_mask = 22'b1;
`endif
    n_cmp++;
    if (got_mask !== exp_mask) begin
      n_fail++;
      $display("[TB] FAIL repeat_mask: got %b expected %b", got_mask, exp_mask);
    end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0000);
      checkOutput("model_release", m_out);
      if (o_Alarm_Min_Inc) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_fail++;
      $display("[TB] FAIL strobes_after_release: got %0d expected 0", extra);
    end

    // Reset asserted mid-hold aborts at once and no strobe follows.
    for (int k = 0; k < 5; k++) applyStimulus(4'b0010);
    @(negedge i_Clk);
    i_Rst_L = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset", 8'h00);
    for (int k = 0; k < 12; k++) begin
      @(posedge i_Clk);
      #1;
      checkOutput("in_reset", 8'h00);
    end
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0010);
      checkOutput("after_reset_hold", 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
